// File: rtl/kmac_msg_absorber_if.sv
// MSG word stream plus Keccak block handshake between the message FIFO side and the absorber.
// Both channels: a transfer happens on a rising clock edge where valid and ready are both 1; valid never waits on ready.
interface kmac_msg_absorber_if #(
    parameter int OutWidth  = 64,
    parameter int RateWords = 17
);
    logic                          msg_valid_i;
    logic [OutWidth-1:0]           msg_data_i;
    logic [OutWidth/8-1:0]         msg_strb_i;
    logic                          msg_ready_o;
    logic                          process_i;
    logic                          block_valid_o;
    logic [RateWords*OutWidth-1:0] block_data_o;
    logic                          block_last_o;
    logic                          block_ready_i;

    modport master (
        output msg_valid_i, msg_data_i, msg_strb_i, process_i, block_ready_i,
        input  msg_ready_o, block_valid_o, block_data_o, block_last_o
    );

    modport slave (
        input  msg_valid_i, msg_data_i, msg_strb_i, process_i, block_ready_i,
        output msg_ready_o, block_valid_o, block_data_o, block_last_o
    );
endinterface

// File: rtl/kmac_msg_absorber.sv
// Packs MSG words into rate-sized Keccak blocks and applies pad10*1 with a domain byte on process.
// Optional macro KMAC_MSG_ABSORBER_BYTECOUNT_EN adds the saturating msg_bytes_o message byte counter.
module kmac_msg_absorber #(
    parameter int          OutWidth   = 64,
    parameter int          RateWords  = 17,
    parameter logic [7:0]  DomainByte = 8'h06
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [3:0]          clear_i,
    kmac_msg_absorber_if.slave  bus,
    output logic                absorbed_o,
    output logic                err_o,
`ifdef KMAC_MSG_ABSORBER_BYTECOUNT_EN
    output logic [31:0]         msg_bytes_o,
`endif
    output logic [1:0]          state_o
);
    localparam int NB        = OutWidth / 8;
    localparam int RateBytes = RateWords * NB;
    localparam int BW        = RateWords * OutWidth;
    localparam int WCW       = $clog2(RateWords + 1);
    localparam int BPW       = $clog2(RateBytes + 1);
    localparam int PCW       = $clog2(NB + 1);
    localparam logic [3:0] MuBi4True = 4'h6;

    typedef enum logic [1:0] {StFill, StPad, StEmit, StDone} state_e;

    state_e         state_q;
    logic [BW-1:0]  blk_q;
    logic [WCW-1:0] word_cnt_q;
    logic [BPW-1:0] byte_pos_q;
    logic           partial_q, proc_pend_q;
    logic           msg_ready_q, block_valid_q, block_last_q, absorbed_q, err_q;

    logic [OutWidth-1:0] data_masked;
    logic [PCW-1:0]      strb_pop;
    logic                accept_ok, strb_full;
    logic [BW-1:0]       fill_buf_d, pad_buf_d;
    logic [BPW-1:0]      fill_pos_d;

    always_comb begin
        data_masked = '0;
        strb_pop    = '0;
        for (int b = 0; b < NB; b++) begin
            if (bus.msg_strb_i[b]) begin
                data_masked[b*8 +: 8] = bus.msg_data_i[b*8 +: 8];
                strb_pop = strb_pop + PCW'(1);
            end
        end
        // Legal strobes are contiguous low bytes; a partial word must be the last one of the message.
        accept_ok = (bus.msg_strb_i != '0) &&
                    ((bus.msg_strb_i & (bus.msg_strb_i + NB'(1))) == '0) && !partial_q;
        strb_full = &bus.msg_strb_i;
        fill_buf_d = blk_q;
        fill_buf_d[word_cnt_q*OutWidth +: OutWidth] = data_masked;
        fill_pos_d = BPW'(word_cnt_q) * BPW'(NB) + BPW'(strb_pop);
        pad_buf_d = blk_q;
        for (int i = 0; i < RateBytes; i++) begin
            if (BPW'(i) == byte_pos_q) pad_buf_d[i*8 +: 8] = pad_buf_d[i*8 +: 8] ^ DomainByte;
        end
        pad_buf_d[BW-1 -: 8] = pad_buf_d[BW-1 -: 8] ^ 8'h80;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i == MuBi4True) begin
            state_q       <= StFill;
            blk_q         <= '0;
            word_cnt_q    <= '0;
            byte_pos_q    <= '0;
            partial_q     <= 1'b0;
            proc_pend_q   <= 1'b0;
            msg_ready_q   <= 1'b1;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            absorbed_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            absorbed_q <= 1'b0;
            case (state_q)
                StFill: begin
                    if (bus.msg_valid_i) begin
                        if (!accept_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            blk_q      <= fill_buf_d;
                            word_cnt_q <= word_cnt_q + WCW'(1);
                            byte_pos_q <= fill_pos_d;
                            if (!strb_full) partial_q <= 1'b1;
                        end
                    end
                    // Full means every rate byte is written; a partial final word still leaves room for padding.
                    if (bus.msg_valid_i && accept_ok && fill_pos_d == BPW'(RateBytes)) begin
                        state_q       <= StEmit;
                        msg_ready_q   <= 1'b0;
                        block_valid_q <= 1'b1;
                        block_last_q  <= 1'b0;
                        proc_pend_q   <= bus.process_i;
                    end else if (bus.process_i || proc_pend_q) begin
                        state_q     <= StPad;
                        msg_ready_q <= 1'b0;
                        proc_pend_q <= 1'b0;
                    end
                end
                StPad: begin
                    blk_q         <= pad_buf_d;
                    state_q       <= StEmit;
                    block_valid_q <= 1'b1;
                    block_last_q  <= 1'b1;
                end
                StEmit: begin
                    if (bus.block_ready_i) begin
                        blk_q         <= '0;
                        word_cnt_q    <= '0;
                        byte_pos_q    <= '0;
                        partial_q     <= 1'b0;
                        block_valid_q <= 1'b0;
                        block_last_q  <= 1'b0;
                        proc_pend_q   <= 1'b0;
                        if (block_last_q) begin
                            state_q    <= StDone;
                            absorbed_q <= 1'b1;
                        end else if (proc_pend_q || bus.process_i) begin
                            state_q <= StPad;
                        end else begin
                            state_q     <= StFill;
                            msg_ready_q <= 1'b1;
                        end
                    end else if (bus.process_i) begin
                        proc_pend_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KMAC_MSG_ABSORBER_BYTECOUNT_EN
    logic [31:0] msg_bytes_q;
    logic [32:0] bytes_sum;
    assign bytes_sum = {1'b0, msg_bytes_q} + 33'(strb_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i == MuBi4True) begin
            msg_bytes_q <= '0;
        end else if (state_q == StFill && bus.msg_valid_i && accept_ok) begin
            msg_bytes_q <= bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
        end
    end
    assign msg_bytes_o = msg_bytes_q;
`endif

    assign bus.msg_ready_o   = msg_ready_q;
    assign bus.block_valid_o = block_valid_q;
    assign bus.block_data_o  = blk_q;
    assign bus.block_last_o  = block_last_q;
    assign absorbed_o        = absorbed_q;
    assign err_o             = err_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_kmac_msg_absorber.sv
// Directed bench for kmac_msg_absorber: block vectors from a table plus error, stall and clear sequences.
module tb_kmac_msg_absorber;
    localparam int OW = 64;
    localparam int RW = 17;
    localparam int BW = OW * RW;

    typedef struct {
        logic [RW-1:0][OW-1:0] words;
        logic [RW-1:0][7:0]    strbs;
        int                    n_words;
        logic                  proc_with_last;
        int                    n_blocks;
        logic [BW-1:0]         exp0;
        logic                  exp_last0;
        logic [BW-1:0]         exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  clear = 4'h9;
    logic        absorbed, err;
    logic [1:0]  state;
    int          total = 0;
    int          passed = 0;
    int          abs_cnt = 0;
    vec_t        vecs[6];
    logic [BW-1:0] pad_only;

    kmac_msg_absorber_if #(.OutWidth(OW), .RateWords(RW)) bus ();

`ifdef KMAC_MSG_ABSORBER_BYTECOUNT_EN
    logic [31:0] msg_bytes;
`endif

    kmac_msg_absorber dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .bus        (bus),
        .absorbed_o (absorbed),
        .err_o      (err),
`ifdef KMAC_MSG_ABSORBER_BYTECOUNT_EN
        .msg_bytes_o(msg_bytes),
`endif
        .state_o    (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (absorbed) abs_cnt++;

    function automatic logic [OW-1:0] pat(input int k);
        return 64'h0101_0101_0101_0101 * 64'(k + 1);
    endfunction

    task automatic check_val(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            for (int w = 0; w < RW; w++) begin
                if (act[w*OW +: OW] !== exp[w*OW +: OW]) begin
                    $display("FAIL %s: word %0d got %h expected %h", name, w, act[w*OW +: OW], exp[w*OW +: OW]);
                    break;
                end
            end
        end
    endtask

    task automatic send_word(input logic [OW-1:0] d, input logic [7:0] s, input logic proc);
        bus.msg_valid_i = 1'b1;
        bus.msg_data_i  = d;
        bus.msg_strb_i  = s;
        bus.process_i   = proc;
        @(negedge clk);
        bus.msg_valid_i = 1'b0;
        bus.process_i   = 1'b0;
    endtask

    task automatic pulse_process();
        bus.process_i = 1'b1;
        @(negedge clk);
        bus.process_i = 1'b0;
    endtask

    task automatic take_block(input string name, input logic [BW-1:0] exp, input logic exp_last);
        int waited = 0;
        while (!bus.block_valid_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_val({name, "_valid"}, 64'(bus.block_valid_o), 64'd1);
        if (bus.block_valid_o) begin
            check_blk({name, "_data"}, bus.block_data_o, exp);
            check_val({name, "_last"}, 64'(bus.block_last_o), 64'(exp_last));
            bus.block_ready_i = 1'b1;
            @(negedge clk);
            bus.block_ready_i = 1'b0;
        end
    endtask

    task automatic do_clear();
        clear = 4'h6;
        @(negedge clk);
        clear = 4'h9;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        abs_cnt = 0;
        for (int k = 0; k < v.n_words; k++)
            send_word(v.words[k], v.strbs[k], v.proc_with_last && (k == v.n_words - 1));
        if (!v.proc_with_last) pulse_process();
        take_block({tag, "_b0"}, v.exp0, v.exp_last0);
        if (v.n_blocks > 1) take_block({tag, "_b1"}, v.exp1, 1'b1);
        repeat (3) @(negedge clk);
        check_val({tag, "_absorbed_once"}, 64'(abs_cnt), 64'd1);
        check_val({tag, "_done_ready"}, 64'(bus.msg_ready_o), 64'd0);
        // Not strict-true: must not leave Done.
        clear = 4'hE;
        @(negedge clk);
        clear = 4'h9;
        check_val({tag, "_weak_clear"}, 64'(bus.msg_ready_o), 64'd0);
        do_clear();
        check_val({tag, "_clear_ready"}, 64'(bus.msg_ready_o), 64'd1);
    endtask

    initial begin
        logic [BW-1:0] e;

        pad_only = '0;
        pad_only[7:0] = 8'h06;
        pad_only[BW-1 -: 8] = 8'h80;
        for (int i = 0; i < 6; i++) begin
            vecs[i].words = '0;
            vecs[i].strbs = '1;
            vecs[i].proc_with_last = 1'b0;
            vecs[i].n_blocks = 1;
            vecs[i].exp_last0 = 1'b1;
            vecs[i].exp1 = '0;
        end
        // Empty message
        vecs[0].n_words = 0;
        vecs[0].exp0 = pad_only;
        // Three full words plus a 3-byte tail: domain byte lands at byte 27
        vecs[1].n_words = 4;
        vecs[1].words[0] = 64'h1111_1111_1111_1111;
        vecs[1].words[1] = 64'h2222_2222_2222_2222;
        vecs[1].words[2] = 64'h3333_3333_3333_3333;
        vecs[1].words[3] = 64'hDEAD_BEEF_FFAA_BBCC;
        vecs[1].strbs[3] = 8'h07;
        e = '0;
        e[0 +: 64] = 64'h1111_1111_1111_1111;
        e[64 +: 64] = 64'h2222_2222_2222_2222;
        e[128 +: 64] = 64'h3333_3333_3333_3333;
        e[192 +: 64] = 64'h0000_0000_06AA_BBCC;
        e[BW-1 -: 8] = 8'h80;
        vecs[1].exp0 = e;
        // Same with a 4-byte tail: domain byte lands at byte 28
        vecs[2] = vecs[1];
        vecs[2].words[3] = 64'hFFFF_FFFF_00AA_BBCC;
        vecs[2].strbs[3] = 8'h0F;
        e[192 +: 64] = 64'h0000_0006_00AA_BBCC;
        vecs[2].exp0 = e;
        // 17 full words with process on the last: data block then pad-only block
        vecs[3].n_words = 17;
        vecs[3].proc_with_last = 1'b1;
        vecs[3].n_blocks = 2;
        vecs[3].exp_last0 = 1'b0;
        for (int k = 0; k < 17; k++) vecs[3].words[k] = pat(k);
        vecs[3].exp0 = vecs[3].words;
        vecs[3].exp1 = pad_only;
        // 16 full words plus a 7-byte word: both pad bytes share byte 135
        vecs[4].n_words = 17;
        for (int k = 0; k < 16; k++) vecs[4].words[k] = pat(k);
        vecs[4].words[16] = 64'h0123_4567_89AB_CDEF;
        vecs[4].strbs[16] = 8'h7F;
        e = vecs[4].words;
        e[16*64 +: 64] = 64'h8623_4567_89AB_CDEF;
        vecs[4].exp0 = e;
        // Process together with a non-filling word
        vecs[5].n_words = 5;
        vecs[5].proc_with_last = 1'b1;
        for (int k = 0; k < 5; k++) vecs[5].words[k] = pat(k);
        e = vecs[5].words;
        e[5*64 +: 64] = 64'h0000_0000_0000_0006;
        e[BW-1 -: 8] = 8'h80;
        vecs[5].exp0 = e;

        bus.msg_valid_i = 1'b0;
        bus.msg_data_i = '0;
        bus.msg_strb_i = '0;
        bus.process_i = 1'b0;
        bus.block_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("rst_msg_ready", 64'(bus.msg_ready_o), 64'd1);
        check_val("rst_block_valid", 64'(bus.block_valid_o), 64'd0);
        check_val("rst_block_last", 64'(bus.block_last_o), 64'd0);
        check_val("rst_absorbed", 64'(absorbed), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_blk("rst_block_data", bus.block_data_o, '0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Illegal strobe: flagged, word dropped
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'h05, 1'b0);
        check_val("err_illegal_strb", 64'(err), 64'd1);
        send_word(64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 1'b0);
        pulse_process();
        e = '0;
        e[0 +: 64] = 64'hA5A5_A5A5_A5A5_A5A5;
        e[64 +: 64] = 64'h0000_0000_0000_0006;
        e[BW-1 -: 8] = 8'h80;
        take_block("err_drop", e, 1'b1);
        check_val("err_sticky", 64'(err), 64'd1);
        do_clear();
        check_val("err_cleared", 64'(err), 64'd0);
        check_val("err_clear_ready", 64'(bus.msg_ready_o), 64'd1);

        // Word after a partial word: flagged, dropped
        send_word(64'h1234_5678_9ABC_DEF0, 8'h03, 1'b0);
        check_val("partial_no_err", 64'(err), 64'd0);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        check_val("err_after_partial", 64'(err), 64'd1);
        pulse_process();
        e = '0;
        e[0 +: 64] = 64'h0000_0000_0006_DEF0;
        e[BW-1 -: 8] = 8'h80;
        take_block("partial_blk", e, 1'b1);
        do_clear();
        check_val("err_cleared2", 64'(err), 64'd0);
        check_val("err_clear_ready2", 64'(bus.msg_ready_o), 64'd1);

        // Back-pressure for 10 cycles, then clear mid-Emit abandons the block
        for (int k = 0; k < 17; k++) send_word(pat(k), 8'hFF, 1'b0);
        check_val("stall_latency", 64'(bus.block_valid_o), 64'd1);
        e = vecs[3].exp0;
        bus.msg_valid_i = 1'b1;
        bus.msg_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
        bus.msg_strb_i = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            check_val($sformatf("stall_valid_c%0d", c), 64'(bus.block_valid_o), 64'd1);
            check_blk($sformatf("stall_data_c%0d", c), bus.block_data_o, e);
            check_val($sformatf("stall_ready_c%0d", c), 64'(bus.msg_ready_o), 64'd0);
            @(negedge clk);
        end
        bus.msg_valid_i = 1'b0;
        clear = 4'h6;
        bus.block_ready_i = 1'b1;
        @(negedge clk);
        clear = 4'h9;
        bus.block_ready_i = 1'b0;
        check_val("clr_emit_valid", 64'(bus.block_valid_o), 64'd0);
        check_blk("clr_emit_data", bus.block_data_o, '0);
        check_val("clr_emit_ready", 64'(bus.msg_ready_o), 64'd1);
        check_val("clr_emit_absorbed", 64'(absorbed), 64'd0);

        // Process arriving during Emit queues a pad-only block
        for (int k = 0; k < 17; k++) send_word(pat(k), 8'hFF, 1'b0);
        pulse_process();
        abs_cnt = 0;
        take_block("emit_proc_b0", vecs[3].exp0, 1'b0);
        take_block("emit_proc_b1", pad_only, 1'b1);
        repeat (2) @(negedge clk);
        check_val("emit_proc_absorbed", 64'(abs_cnt), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
